hash_msg_feeder: RTL and testbench

- Front end for the DES-S-box byte hash core.
- Accepts a message length command, then the message bytes over a valid/ready stream, buffering them in a small FIFO.
- Issues bytes to the core one at a time as single-cycle m_valid pulses, spaced so the core can finish its four rounds per byte, and holds the 64-bit length counter stable for the core.
- Waits for the core's hash_ready, then captures the 32-bit digest and presents it with a valid/ack handshake.

---
 rtl/hash_msg_feeder_if.sv | 9 +
 rtl/hash_msg_feeder.sv | 157 +++++++++++++++
 tb/tb_hash_msg_feeder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hash_msg_feeder_if.sv
// rtl/hash_msg_feeder_if.sv - message byte stream into the hash feeder
interface hash_msg_feeder_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/hash_msg_feeder.sv
// rtl/hash_msg_feeder.sv - buffers message bytes and paces them into the DES-S-box hash core
module hash_msg_feeder #(
  parameter int FIFO_DEPTH = 16,
  parameter int BYTE_GAP   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [63:0]         len_in,
  hash_msg_feeder_if.slave    s,
  output logic                busy,
  output logic                cmd_err,
  output logic [7:0]          core_message,
  output logic                core_m_valid,
  output logic [63:0]         core_counter,
  input  logic                core_hash_ready,
  input  logic [31:0]         core_digest,
  output logic [31:0]         digest_out,
  output logic                digest_valid,
  input  logic                digest_ack
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (BYTE_GAP > 2) ? $clog2(BYTE_GAP - 1) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'(BYTE_GAP - 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP,
    ST_WAIT_HASH,
    ST_DONE
  } state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [63:0]     remaining;
  logic [63:0]     accepted;
  logic [GW-1:0]   gap;

  logic            push;
  logic            pop;
  logic            in_cmd;
  logic            active_nxt;
  logic [AW:0]     count_nxt;
  logic [63:0]     acc_nxt;
  logic [63:0]     ctr_nxt;
  logic            ready_nxt;

  // s_ready is registered, so it is computed from the values the flops will hold next cycle.
  always_comb begin
    push       = s.s_valid && s.s_ready;
    pop        = (state == ST_ISSUE) && (count != '0);
    in_cmd     = (state == ST_IDLE) && start && (len_in != 64'd0);
    count_nxt  = count + (AW + 1)'(push) - (AW + 1)'(pop);
    acc_nxt    = in_cmd ? 64'd0 : accepted + 64'(push);
    ctr_nxt    = in_cmd ? len_in : core_counter;
    active_nxt = in_cmd || (state == ST_ISSUE) ||
                 ((state == ST_GAP) && !((gap == '0) && (remaining == 64'd0)));
    ready_nxt  = active_nxt && (count_nxt != FULL_CNT) && (acc_nxt < ctr_nxt);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s.s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      s.s_ready    <= 1'b0;
      busy         <= 1'b0;
      cmd_err      <= 1'b0;
      core_message <= 8'd0;
      core_m_valid <= 1'b0;
      core_counter <= 64'd0;
      digest_out   <= 32'd0;
      digest_valid <= 1'b0;
      remaining    <= 64'd0;
      accepted     <= 64'd0;
      gap          <= '0;
    end else begin
      s.s_ready    <= ready_nxt;
      accepted     <= acc_nxt;
      core_counter <= ctr_nxt;
      core_m_valid <= 1'b0;
      cmd_err      <= start && (state != ST_IDLE);

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len_in != 64'd0) begin
              remaining <= len_in;
              busy      <= 1'b1;
              state     <= ST_ISSUE;
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (pop) begin
            core_message <= mem[rd_ptr];
            core_m_valid <= 1'b1;
            remaining    <= remaining - 64'd1;
            gap          <= GAP_LOAD;
            state        <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap == '0) begin
            state <= (remaining == 64'd0) ? ST_WAIT_HASH : ST_ISSUE;
          end else begin
            gap <= gap - 1'b1;
          end
        end
        ST_WAIT_HASH: begin
          if (core_hash_ready) begin
            digest_out   <= core_digest;
            digest_valid <= 1'b1;
            state        <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (digest_ack) begin
            digest_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_msg_feeder.sv
// tb/tb_hash_msg_feeder.sv - self-checking bench for hash_msg_feeder
module tb_hash_msg_feeder;
  localparam int FIFO_DEPTH = 16;
  localparam int BYTE_GAP   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] len_in = 64'd0;
  logic        busy, cmd_err, core_m_valid, digest_valid;
  logic [7:0]  core_message;
  logic [63:0] core_counter;
  logic        core_hash_ready = 1'b0;
  logic [31:0] core_digest = 32'd0;
  logic [31:0] digest_out;
  logic        digest_ack = 1'b0;

  hash_msg_feeder_if bus ();

  hash_msg_feeder #(.FIFO_DEPTH(FIFO_DEPTH), .BYTE_GAP(BYTE_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len_in(len_in), .s(bus),
    .busy(busy), .cmd_err(cmd_err), .core_message(core_message),
    .core_m_valid(core_m_valid), .core_counter(core_counter),
    .core_hash_ready(core_hash_ready), .core_digest(core_digest),
    .digest_out(digest_out), .digest_valid(digest_valid), .digest_ack(digest_ack)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // model state
  logic [7:0]  src_q[$];
  logic [7:0]  exp_q[$];
  int          pe_q[$];
  logic [7:0]  pb_q[$];
  int          xe_q[$];
  logic        m_busy = 1'b0;
  logic        m_err_due = 1'b0;
  logic [63:0] m_len = 64'd0;
  logic [63:0] m_acc = 64'd0;
  logic [63:0] m_pulses = 64'd0;
  logic [63:0] occ;
  logic [63:0] max_occ = 64'd0;
  logic        saw_stall = 1'b0;
  int          last_pe = 0;
  int          err_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // producer: offers src_q bytes in order, advancing only on a handshake
  initial begin
    logic xfer;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'd0;
    forever begin
      @(negedge clk);
      xfer = rst_n && bus.s_valid && bus.s_ready;
      @(posedge clk);
      #1;
      if (xfer && src_q.size() > 0) void'(src_q.pop_front());
      bus.s_valid = (src_q.size() > 0);
      bus.s_data  = (src_q.size() > 0) ? src_q[0] : 8'd0;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_err_due = 1'b0; m_len = 0; m_acc = 0; m_pulses = 0;
      exp_q.delete();
    end else begin
      if (core_m_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL core_byte: pulse %0h with no accepted byte pending", core_message);
        end else begin
          if (core_message !== exp_q[0]) begin
            fails++;
            $display("FAIL core_byte: got %0h expected %0h", core_message, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        if (m_pulses > 0) check("pulse_spacing_min", 64'(cyc - last_pe >= BYTE_GAP), 64'd1);
        pe_q.push_back(cyc);
        pb_q.push_back(core_message);
        last_pe = cyc;
        m_pulses++;
      end
      occ = m_acc - m_pulses;
      if (occ > max_occ) max_occ = occ;
      check("s_ready", 64'(bus.s_ready), 64'(m_busy && (m_acc < m_len) && (occ < FIFO_DEPTH)));
      check("busy", 64'(busy), 64'(m_busy));
      check("cmd_err", 64'(cmd_err), 64'(m_err_due));
      if (m_busy) check("core_counter", core_counter, m_len);
      if (cmd_err) err_count++;
      if (m_busy && (m_acc < m_len) && !bus.s_ready) saw_stall = 1'b1;

      m_err_due = start && (m_busy || (len_in == 64'd0));
      if (bus.s_valid && bus.s_ready) begin
        exp_q.push_back(bus.s_data);
        xe_q.push_back(cyc + 1);
        m_acc++;
      end
      if (start && !m_busy && (len_in != 64'd0)) begin
        m_busy = 1'b1; m_len = len_in; m_acc = 0; m_pulses = 0;
        exp_q.delete(); pe_q.delete(); pb_q.delete(); xe_q.delete();
      end
      if (digest_valid && digest_ack) m_busy = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [63:0] len);
    start = 1'b1;
    len_in = len;
    tick(1);
    start = 1'b0;
    len_in = 64'd0;
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k = 0;
    while (m_pulses < 64'(n) && k < budget) begin
      tick(1);
      k++;
    end
    check("wait_pulses", m_pulses, 64'(n));
  endtask

  task automatic finish_hash(input logic [31:0] dig);
    tick(BYTE_GAP + 2);
    core_digest = dig;
    core_hash_ready = 1'b1;
    tick(1);
    core_hash_ready = 1'b0;
    core_digest = 32'd0;
    check("digest_valid_set", 64'(digest_valid), 64'd1);
    check("digest_out", 64'(digest_out), 64'(dig));
    tick(3);
    check("digest_valid_held", 64'(digest_valid), 64'd1);
    check("digest_out_held", 64'(digest_out), 64'(dig));
    digest_ack = 1'b1;
    tick(1);
    digest_ack = 1'b0;
    check("digest_valid_clr", 64'(digest_valid), 64'd0);
    check("busy_after_ack", 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, 64'(bus.s_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_cmd_err"}, 64'(cmd_err), 64'd0);
    check({tag, "_core_message"}, 64'(core_message), 64'd0);
    check({tag, "_core_m_valid"}, 64'(core_m_valid), 64'd0);
    check({tag, "_core_counter"}, core_counter, 64'd0);
    check({tag, "_digest_out"}, 64'(digest_out), 64'd0);
    check({tag, "_digest_valid"}, 64'(digest_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int e0;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // 1: three bytes back-to-back, pulses exactly BYTE_GAP apart
    src_q = '{8'h61, 8'h62, 8'h63};
    do_start(64'd3);
    wait_pulses(3, 100);
    check("t1_byte0", 64'(pb_q[0]), 64'h61);
    check("t1_byte1", 64'(pb_q[1]), 64'h62);
    check("t1_byte2", 64'(pb_q[2]), 64'h63);
    check("t1_gap01", 64'(pe_q[1] - pe_q[0]), 64'd4);
    check("t1_gap12", 64'(pe_q[2] - pe_q[1]), 64'd4);
    check("t1_counter", core_counter, 64'd3);
    finish_hash(32'hDEADBEEF);

    // 2: FIFO fills to depth and backpressures
    for (int i = 0; i < 40; i++) src_q.push_back(8'((i * 7 + 3) & 8'hFF));
    max_occ = 0;
    saw_stall = 1'b0;
    do_start(64'd40);
    wait_pulses(40, 300);
    check("t2_max_occ", max_occ, 64'd16);
    check("t2_backpressure", 64'(saw_stall), 64'd1);
    check("t2_pending", 64'(exp_q.size()), 64'd0);
    check("t2_last_byte", 64'(pb_q[39]), 64'((39 * 7 + 3) & 8'hFF));
    finish_hash(32'hCAFEF00D);

    // 3: surplus bytes are never taken
    src_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    do_start(64'd2);
    wait_pulses(2, 100);
    tick(5);
    check("t3_accepted", m_acc, 64'd2);
    check("t3_untouched", 64'(src_q.size()), 64'd3);
    check("t3_s_ready", 64'(bus.s_ready), 64'd0);
    check("t3_pulses", 64'(pe_q.size()), 64'd2);
    finish_hash(32'h0BADF00D);
    src_q.delete();
    tick(2);

    // 4: zero-length start and start while busy
    e0 = err_count;
    do_start(64'd0);
    tick(2);
    check("t4_err_len0", 64'(err_count - e0), 64'd1);
    check("t4_idle", 64'(busy), 64'd0);
    src_q = '{8'h31, 8'h32, 8'h33};
    do_start(64'd3);
    wait_pulses(1, 100);
    do_start(64'd7);
    check("t4_counter_kept", core_counter, 64'd3);
    tick(1);
    check("t4_err_busy", 64'(err_count - e0), 64'd2);
    wait_pulses(3, 100);
    check("t4_counter_end", core_counter, 64'd3);
    finish_hash(32'h01020304);

    // 5: producer stall with empty FIFO
    src_q = '{8'h11, 8'h22};
    do_start(64'd4);
    wait_pulses(2, 100);
    tick(10);
    check("t5_no_pulse_stall", m_pulses, 64'd2);
    check("t5_busy_stall", 64'(busy), 64'd1);
    src_q.push_back(8'h33);
    src_q.push_back(8'h44);
    wait_pulses(4, 100);
    check("t5_resume_latency", 64'(pe_q[2] - xe_q[2]), 64'd1);
    check("t5_byte3", 64'(pb_q[3]), 64'h44);
    finish_hash(32'h55AA55AA);

    // 6: reset mid-message, then a clean one-byte command
    for (int i = 0; i < 8; i++) src_q.push_back(8'(8'hC0 + i));
    do_start(64'd8);
    wait_pulses(3, 100);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_reset");
    src_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    src_q = '{8'h5A};
    do_start(64'd1);
    wait_pulses(1, 100);
    check("t6_first_byte", 64'(pb_q[0]), 64'h5A);
    check("t6_counter", core_counter, 64'd1);
    finish_hash(32'h12345678);

    tick(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
